// File: rtl/alu_result_stage.sv
// Registered 2-entry skid buffer for ALU result words, with sticky flag and
// accepted-result count status for the sequencing controller.
//
// state | meaning
// EMPTY | no word held, out_valid=0
// ONE   | output register holds a word, skid entry free
// TWO   | output and skid entries both hold words, upstream stalled
module alu_result_stage #(
  parameter int W_R   = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_R-1:0]   R_in,
  input  logic             DZF_in,
  input  logic             SF_in,
  input  logic             ZF_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_R-1:0]   R,
  output logic             DZF,
  output logic             SF,
  output logic             ZF,
  input  logic             clr_sticky,
  output logic             DZF_sticky,
  output logic             SF_sticky,
  output logic             ZF_sticky,
  output logic [CNT_W-1:0] res_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [W_R-1:0]   out_r_q, out_r_d, skid_r_q, skid_r_d;
  logic             out_dzf_q, out_dzf_d, out_sf_q, out_sf_d, out_zf_q, out_zf_d;
  logic             skid_dzf_q, skid_dzf_d, skid_sf_q, skid_sf_d, skid_zf_q, skid_zf_d;
  logic             dzf_st_q, dzf_st_d, sf_st_q, sf_st_d, zf_st_q, zf_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept, pop;
  logic [W_R-1:0]   m_r;
  logic             m_sf, m_zf;

  assign accept = in_valid & in_ready_q;
  assign pop    = (state_q != EMPTY) & out_ready;

  // A divide-by-zero word carries no meaningful result or sign/zero flags.
  assign m_r  = DZF_in ? '0 : R_in;
  assign m_sf = DZF_in ? 1'b0 : SF_in;
  assign m_zf = DZF_in ? 1'b0 : ZF_in;

  always_comb begin
    state_d    = state_q;
    out_r_d    = out_r_q;
    out_dzf_d  = out_dzf_q;
    out_sf_d   = out_sf_q;
    out_zf_d   = out_zf_q;
    skid_r_d   = skid_r_q;
    skid_dzf_d = skid_dzf_q;
    skid_sf_d  = skid_sf_q;
    skid_zf_d  = skid_zf_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          out_r_d   = m_r;
          out_dzf_d = DZF_in;
          out_sf_d  = m_sf;
          out_zf_d  = m_zf;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_d    = TWO;
          skid_r_d   = m_r;
          skid_dzf_d = DZF_in;
          skid_sf_d  = m_sf;
          skid_zf_d  = m_zf;
        end else if (accept && pop) begin
          out_r_d   = m_r;
          out_dzf_d = DZF_in;
          out_sf_d  = m_sf;
          out_zf_d  = m_zf;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d   = ONE;
          out_r_d   = skid_r_q;
          out_dzf_d = skid_dzf_q;
          out_sf_d  = skid_sf_q;
          out_zf_d  = skid_zf_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is a register so it never depends combinationally on out_ready.
  assign in_ready_d = (state_d != TWO);

  always_comb begin
    dzf_st_d = dzf_st_q;
    sf_st_d  = sf_st_q;
    zf_st_d  = zf_st_q;
    cnt_d    = cnt_q;
    if (clr_sticky) begin
      dzf_st_d = accept & DZF_in;
      sf_st_d  = accept & m_sf;
      zf_st_d  = accept & m_zf;
      cnt_d    = accept ? CNT_W'(1) : '0;
    end else if (accept) begin
      dzf_st_d = dzf_st_q | DZF_in;
      sf_st_d  = sf_st_q | m_sf;
      zf_st_d  = zf_st_q | m_zf;
      if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      out_r_q    <= '0;
      out_dzf_q  <= 1'b0;
      out_sf_q   <= 1'b0;
      out_zf_q   <= 1'b0;
      skid_r_q   <= '0;
      skid_dzf_q <= 1'b0;
      skid_sf_q  <= 1'b0;
      skid_zf_q  <= 1'b0;
      dzf_st_q   <= 1'b0;
      sf_st_q    <= 1'b0;
      zf_st_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_r_q    <= out_r_d;
      out_dzf_q  <= out_dzf_d;
      out_sf_q   <= out_sf_d;
      out_zf_q   <= out_zf_d;
      skid_r_q   <= skid_r_d;
      skid_dzf_q <= skid_dzf_d;
      skid_sf_q  <= skid_sf_d;
      skid_zf_q  <= skid_zf_d;
      dzf_st_q   <= dzf_st_d;
      sf_st_q    <= sf_st_d;
      zf_st_q    <= zf_st_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign R          = out_r_q;
  assign DZF        = out_dzf_q;
  assign SF         = out_sf_q;
  assign ZF         = out_zf_q;
  assign DZF_sticky = dzf_st_q;
  assign SF_sticky  = sf_st_q;
  assign ZF_sticky  = zf_st_q;
  assign res_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: handshake, ordering, DZF masking,
// sticky/counter behaviour, reset flush and counter saturation.
module tb_alu_result_stage;

  localparam int W_R   = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W_R-1:0]   R_in;
  logic             DZF_in, SF_in, ZF_in;
  logic             out_valid;
  logic             out_ready;
  logic [W_R-1:0]   R;
  logic             DZF, SF, ZF;
  logic             clr_sticky;
  logic             DZF_sticky, SF_sticky, ZF_sticky;
  logic [CNT_W-1:0] res_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.W_R(W_R), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .R_in       (R_in),
    .DZF_in     (DZF_in),
    .SF_in      (SF_in),
    .ZF_in      (ZF_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .R          (R),
    .DZF        (DZF),
    .SF         (SF),
    .ZF         (ZF),
    .clr_sticky (clr_sticky),
    .DZF_sticky (DZF_sticky),
    .SF_sticky  (SF_sticky),
    .ZF_sticky  (ZF_sticky),
    .res_cnt    (res_cnt)
  );

  // Advance one clock; sampling and driving both happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; R_in = '0; DZF_in = 0; SF_in = 0; ZF_in = 0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    step(); step();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (R !== 5'b00000) $display("FAIL reset_R got %b want 00000", R); else passed++;
    total++; if (res_cnt !== 8'd0) $display("FAIL reset_res_cnt got %0d want 0", res_cnt); else passed++;
    total++; if ({DZF_sticky, SF_sticky, ZF_sticky} !== 3'b000)
      $display("FAIL reset_sticky got %b want 000", {DZF_sticky, SF_sticky, ZF_sticky}); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    in_valid = 1'b1; R_in = 5'b00010; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got %b want 1", out_valid); else passed++;
    total++; if (R !== 5'b00010) $display("FAIL single_R got %b want 00010", R); else passed++;
    total++; if (res_cnt !== 8'd1) $display("FAIL single_res_cnt got %0d want 1", res_cnt); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL single_drain got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; R_in = 5'b00001;
    step();
    total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_one got %b want 1", in_ready); else passed++;
    R_in = 5'b00010;
    step();
    total++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_two got %b want 0", in_ready); else passed++;
    R_in = 5'b00011;
    step();
    total++; if (R !== 5'b00001) $display("FAIL b2b_stall_R got %b want 00001", R); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL b2b_stall_ready got %b want 0", in_ready); else passed++;
    out_ready = 1'b1;
    step();
    total++; if (R !== 5'b00010) $display("FAIL b2b_second got %b want 00010", R); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_back got %b want 1", in_ready); else passed++;
    step();
    in_valid = 1'b0;
    total++; if (R !== 5'b00011 || out_valid !== 1'b1)
      $display("FAIL b2b_third got R=%b v=%b want 00011 v=1", R, out_valid); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else passed++;
    total++; if (res_cnt !== 8'd4) $display("FAIL b2b_res_cnt got %0d want 4", res_cnt); else passed++;
  endtask

  task automatic test_dzf_mask();
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    total++; if (res_cnt !== 8'd0) $display("FAIL clr_res_cnt got %0d want 0", res_cnt); else passed++;
    out_ready = 1'b0; in_valid = 1'b1; R_in = 5'b10111; DZF_in = 1; SF_in = 1; ZF_in = 0;
    step();
    in_valid = 1'b0; DZF_in = 0; SF_in = 0;
    total++; if ({R, DZF, SF, ZF} !== 8'b00000_100)
      $display("FAIL dzf_word got R=%b D=%b S=%b Z=%b want 00000 1 0 0", R, DZF, SF, ZF); else passed++;
    total++; if (DZF_sticky !== 1'b1 || SF_sticky !== 1'b0)
      $display("FAIL dzf_sticky got D=%b S=%b want D=1 S=0", DZF_sticky, SF_sticky); else passed++;
    total++; if (res_cnt !== 8'd1) $display("FAIL dzf_res_cnt got %0d want 1", res_cnt); else passed++;
    step();
    total++; if (R !== 5'b00000 || DZF !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL hold_stable got R=%b D=%b v=%b want 00000 1 1", R, DZF, out_valid); else passed++;
  endtask

  task automatic test_clr_with_accept();
    clr_sticky = 1'b1; in_valid = 1'b1; R_in = 5'b00000; DZF_in = 0; SF_in = 0; ZF_in = 1;
    step();
    clr_sticky = 1'b0; in_valid = 1'b0; ZF_in = 0;
    total++; if (DZF_sticky !== 1'b0 || ZF_sticky !== 1'b1)
      $display("FAIL clr_acc_sticky got D=%b Z=%b want D=0 Z=1", DZF_sticky, ZF_sticky); else passed++;
    total++; if (res_cnt !== 8'd1) $display("FAIL clr_acc_res_cnt got %0d want 1", res_cnt); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL clr_acc_full got %b want 0", in_ready); else passed++;
  endtask

  task automatic test_reset_in_two();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst2_hs got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); else passed++;
    total++; if (res_cnt !== 8'd0 || {DZF_sticky, SF_sticky, ZF_sticky} !== 3'b000)
      $display("FAIL rst2_status got cnt=%0d st=%b want 0 000", res_cnt, {DZF_sticky, SF_sticky, ZF_sticky}); else passed++;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL rst2_no_replay got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; in_valid = 1'b1; R_in = 5'b00101;
    for (int i = 1; i <= 260; i++) begin
      step();
      if (i == 254) begin
        total++; if (res_cnt !== 8'd254) $display("FAIL sat_254 got %0d want 254", res_cnt); else passed++;
      end
      if (i == 255) begin
        total++; if (res_cnt !== 8'd255) $display("FAIL sat_255 got %0d want 255", res_cnt); else passed++;
      end
    end
    in_valid = 1'b0;
    total++; if (res_cnt !== 8'd255) $display("FAIL sat_hold got %0d want 255", res_cnt); else passed++;
    total++; if (R !== 5'b00101 || out_valid !== 1'b1)
      $display("FAIL sat_stream got R=%b v=%b want 00101 1", R, out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_dzf_mask();
    test_clr_with_accept();
    test_reset_in_two();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
